// File: rtl/twobit_26x18_mesh_pkg.sv
// Shared constants and index helpers for the toroidal 2-bit mesh.
// Cells are numbered row-major; both neighbour lookups wrap around the mesh edges.
package mesh_pkg;

  localparam int ROWS   = 26;
  localparam int COLS   = 18;
  localparam int THRESH = 5;
  localparam int CELLS  = ROWS * COLS;

  function automatic int cell_index(input int r, input int c, input int cols);
    return r * cols + c;
  endfunction

  // Column 0 takes its west value from the last column of the same row.
  function automatic int west_of(input int k, input int cols);
    int r;
    int c;
    r = k / cols;
    c = k % cols;
    return r * cols + ((c + cols - 1) % cols);
  endfunction

  // Row 0 takes its north value from the last row of the same column.
  function automatic int north_of(input int k, input int rows, input int cols);
    int r;
    int c;
    r = k / cols;
    c = k % cols;
    return ((r + rows - 1) % rows) * cols + c;
  endfunction

endpackage

// File: rtl/twobit_26x18_mesh_cell.sv
// One mesh cell: adds its own, west and north registered values and
// registers whether that sum reaches the threshold.
module mesh_cell #(
  parameter int THRESH = mesh_pkg::THRESH
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_own,
  input  logic [1:0] i_west,
  input  logic [1:0] i_north,
  output logic       o_flag
);

  logic [3:0] w_sum;
  logic       r_flag;

  // Three 2-bit operands peak at 9, so 4 bits never overflow.
  assign w_sum = 4'(i_own) + 4'(i_west) + 4'(i_north);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_flag <= 1'b0;
    end else begin
      r_flag <= (w_sum >= 4'(THRESH));
    end
  end

  assign o_flag = r_flag;

endmodule

// File: rtl/twobit_26x18_mesh.sv
// Toroidal mesh of 2-bit cells: registers the flat input bus, then every
// cell flags whether own + west + north reaches THRESH, two edges after sampling.
module twobit_26x18_mesh
  import mesh_pkg::*;
#(
  parameter int ROWS   = mesh_pkg::ROWS,
  parameter int COLS   = mesh_pkg::COLS,
  parameter int THRESH = mesh_pkg::THRESH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [2*ROWS*COLS-1:0]     inp,
  output logic [ROWS*COLS-1:0]       out
);

  localparam int NCELLS = ROWS * COLS;

  logic [NCELLS-1:0][1:0] r_in_q;
  logic [NCELLS-1:0]      w_flags;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_in_q <= '0;
    end else begin
      r_in_q <= inp;
    end
  end

  genvar gi, gj;
  generate
    for (gi = 0; gi < ROWS; gi++) begin : g_row
      for (gj = 0; gj < COLS; gj++) begin : g_col
        localparam int K  = cell_index(gi, gj, COLS);
        localparam int KW = west_of(K, COLS);
        localparam int KN = north_of(K, ROWS, COLS);

        mesh_cell #(
          .THRESH (THRESH)
        ) u_cell (
          .clk     (clk),
          .rst     (rst),
          .i_own   (r_in_q[K]),
          .i_west  (r_in_q[KW]),
          .i_north (r_in_q[KN]),
          .o_flag  (w_flags[K])
        );
      end
    end
  endgenerate

  assign out = w_flags;

endmodule

// File: tb/tb_twobit_26x18_mesh.sv
// Scoreboard bench for twobit_26x18_mesh: directed wrap/threshold/reset cases
// plus a random stream checked against a plain-arithmetic mesh model.
module tb_twobit_26x18_mesh;

  localparam int R = 26;
  localparam int C = 18;
  localparam int N = R * C;
  localparam int W = 2 * N;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] inp = '0;
  logic [N-1:0] out;

  twobit_26x18_mesh dut (
    .clk (clk),
    .rst (rst),
    .inp (inp),
    .out (out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] exp;
    string        name;
  } exp_t;

  exp_t         sb_q[$];
  int           n_tests = 0;
  int           n_fail  = 0;
  int           cyc     = 0;
  logic [W-1:0] m_inq   = '0;

  // Reference: for each (row, col) add the three neighbouring values directly.
  function automatic logic [N-1:0] ref_mesh(input logic [W-1:0] v);
    logic [N-1:0] res;
    int own, wv, nv, wc, nr;
    res = '0;
    for (int r = 0; r < R; r++) begin
      for (int c = 0; c < C; c++) begin
        wc  = (c == 0) ? C - 1 : c - 1;
        nr  = (r == 0) ? R - 1 : r - 1;
        own = int'(v[2*(r*C+c) +: 2]);
        wv  = int'(v[2*(r*C+wc) +: 2]);
        nv  = int'(v[2*(nr*C+c) +: 2]);
        res[r*C+c] = ((own + wv + nv) >= 5);
      end
    end
    return res;
  endfunction

  function automatic logic [W-1:0] fill(input logic [1:0] p);
    logic [W-1:0] v;
    for (int k = 0; k < N; k++) v[2*k +: 2] = p;
    return v;
  endfunction

  // Drive one cycle; expected out after the coming edge comes from the model.
  task automatic step(input logic [W-1:0] v, input logic r, input string name);
    exp_t e;
    @(negedge clk);
    e.exp  = r ? '0 : ref_mesh(m_inq);
    e.name = name;
    sb_q.push_back(e);
    m_inq = r ? '0 : v;
    inp   = v;
    rst   = r;
  endtask

  // Drive one cycle with a hand-derived expected value for the coming edge.
  task automatic step_const(input logic [W-1:0] v, input logic r,
                            input logic [N-1:0] ex, input string name);
    exp_t e;
    @(negedge clk);
    e.exp  = ex;
    e.name = name;
    sb_q.push_back(e);
    m_inq = r ? '0 : v;
    inp   = v;
    rst   = r;
  endtask

  // Monitor: one comparison per edge that has a queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        n_tests++;
        if (out !== e.exp) begin
          n_fail++;
          $display("FAIL %s cyc=%0d got=%h exp=%h", e.name, cyc, out, e.exp);
        end else begin
          $display("[TB] ok %s cyc=%0d", e.name, cyc);
        end
      end
    end
  end

  initial begin
    logic [W-1:0] v, prev;
    logic [N-1:0] ex;
    int           budget;

    // Reset held with all-ones input, then released.
    for (int i = 0; i < 3; i++) step_const(fill(2'b11), 1'b1, '0, "reset_hold");
    step_const(fill(2'b11), 1'b0, '0, "reset_rel_e1");
    step_const(fill(2'b11), 1'b0, '1, "reset_rel_e2");

    // Uniform patterns: second edge after applying shows the pattern result.
    step(fill(2'b01), 1'b0, "u01_e1");
    step_const(fill(2'b01), 1'b0, '0, "u01_sum3");
    step(fill(2'b11), 1'b0, "u11_e1");
    step_const(fill(2'b11), 1'b0, '1, "u11_sum9");
    step(fill(2'b10), 1'b0, "u10_e1");
    step_const(fill(2'b10), 1'b0, '1, "u10_sum6");

    // West wrap: cell 0 sees cell 17 as its west neighbour.
    v = '0; v[1:0] = 2'b11; v[35:34] = 2'b10;
    ex = '0; ex[0] = 1'b1;
    step(v, 1'b0, "wwrap_e1");
    step_const(v, 1'b0, ex, "west_wrap");

    // North wrap: cell 5 sees cell 455 as north and cell 4 as west.
    v = '0; v[2*455 +: 2] = 2'b11; v[2*4 +: 2] = 2'b10;
    ex = '0; ex[5] = 1'b1;
    step(v, 1'b0, "nwrap_e1");
    step_const(v, 1'b0, ex, "north_wrap");

    // Threshold boundary at cell 20 (row 1, col 2): 4 then 5.
    v = '0; v[2*20 +: 2] = 2'b10; v[2*19 +: 2] = 2'b10;
    step(v, 1'b0, "th4_e1");
    step_const(v, 1'b0, '0, "thresh_sum4");
    v[2*2 +: 2] = 2'b01;
    ex = '0; ex[20] = 1'b1;
    step(v, 1'b0, "th5_e1");
    step_const(v, 1'b0, ex, "thresh_sum5");

    // Random stream with a one-cycle reset in the middle.
    prev = '0;
    for (int i = 0; i < 120; i++) begin
      for (int j = 0; j < W; j += 32) begin
        prev = {prev[W-33:0], 32'($urandom)};
      end
      v = prev;
      step(v, (i == 60) ? 1'b1 : 1'b0, (i == 60) ? "rand_midrst" : "rand");
    end
    step(v, 1'b0, "drain1");
    step(v, 1'b0, "drain2");

    budget = 20;
    while (sb_q.size() > 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    #2;
    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain left=%0d exp=0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
